// File: rtl/mm_stream_tx.sv
// Serializes host-written matrices A then B onto the multiplier stream and captures its results.
// Optional WAIT_RES watchdog enabled by defining MM_TX_TIMEOUT_EN.
module mm_stream_tx #(
  parameter int MAX_DIM = 4,
  parameter int DW      = 8,
  parameter int RW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [3:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic [2:0]    a_rows,
  input  logic [2:0]    a_cols,
  input  logic [2:0]    b_rows,
  input  logic [2:0]    b_cols,
  input  logic          start,
  output logic          ready,
  output logic [DW-1:0] tx_data,
  output logic          col_end,
  output logic          row_end,
  input  logic          mm_busy,
  input  logic          mm_valid,
  input  logic [RW-1:0] mm_data,
  output logic          res_valid,
  output logic [RW-1:0] res_data,
  output logic [4:0]    res_count,
  output logic          done,
  output logic          err
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RX, S_SEND_A, S_GAP, S_SEND_B, S_WAIT_RES, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    r_q, r_d, c_q, c_d;
  logic [2:0]    ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
  logic [4:0]    exp_q, exp_d;
  logic          mmv_q;
  logic          ready_q, ready_d;
  logic [DW-1:0] tx_q, tx_d;
  logic          ce_q, ce_d, re_q, re_d;
  logic          rv_q, rv_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          done_q, done_d, err_q, err_d;
  logic [7:0]    wd_q, wd_d;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  // Operand storage is deliberately not reset so a transfer can be replayed after an abort.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE) begin
      if (cfg_sel) mem_b[cfg_addr] <= cfg_data;
      else         mem_a[cfg_addr] <= cfg_data;
    end
  end

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'(MAX_DIM));
  endfunction

  logic          dims_legal, last_c, last_r, rise;
  logic [2:0]    rows, cols;
  logic [DW-1:0] elem;

  assign dims_legal = dim_ok(a_rows) && dim_ok(a_cols) && dim_ok(b_rows) && dim_ok(b_cols);
  assign rows   = (state_q == S_SEND_A) ? ar_q : br_q;
  assign cols   = (state_q == S_SEND_A) ? ac_q : bc_q;
  assign elem   = (state_q == S_SEND_A) ? mem_a[{r_q, c_q}] : mem_b[{r_q, c_q}];
  assign last_c = ({1'b0, c_q} == cols - 3'd1);
  assign last_r = ({1'b0, r_q} == rows - 3'd1);
  assign rise   = mm_valid && !mmv_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    ar_d    = ar_q;
    ac_d    = ac_q;
    br_d    = br_q;
    bc_d    = bc_q;
    exp_d   = exp_q;
    tx_d    = '0;
    ce_d    = 1'b0;
    re_d    = 1'b0;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && ready_q) begin
          if (dims_legal) begin
            ar_d    = a_rows;
            ac_d    = a_cols;
            br_d    = b_rows;
            bc_d    = b_cols;
            // Mismatched inner dimensions produce a single illegal response from the receiver.
            exp_d   = (a_cols == b_rows) ? ({2'b00, a_rows} * {2'b00, b_cols}) : 5'd1;
            cnt_d   = '0;
            state_d = S_WAIT_RX;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT_RX: begin
        if (!mm_busy) begin
          r_d     = '0;
          c_d     = '0;
          state_d = S_SEND_A;
        end
      end
      S_SEND_A, S_SEND_B: begin
        tx_d = elem;
        ce_d = last_c;
        re_d = last_c && last_r;
        if (last_c) begin
          c_d = '0;
          r_d = r_q + 2'd1;
          if (last_r) begin
            r_d     = '0;
            wd_d    = '0;
            state_d = (state_q == S_SEND_A) ? S_GAP : S_WAIT_RES;
          end
        end else begin
          c_d = c_q + 2'd1;
        end
      end
      S_GAP: state_d = S_SEND_B;
      S_WAIT_RES: begin
        if (rise) begin
          rv_d  = 1'b1;
          rd_d  = mm_data;
          cnt_d = cnt_q + 5'd1;
          wd_d  = '0;
          if (cnt_q + 5'd1 == exp_q) state_d = S_DONE;
        end
`ifdef MM_TX_TIMEOUT_EN
        else if (wd_q == 8'd254) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // ready trails the done pulse by one cycle so the host sees done before re-arming.
    ready_d = (state_d == S_IDLE) && !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      ar_q    <= '0;
      ac_q    <= '0;
      br_q    <= '0;
      bc_q    <= '0;
      exp_q   <= '0;
      mmv_q   <= 1'b0;
      ready_q <= 1'b1;
      tx_q    <= '0;
      ce_q    <= 1'b0;
      re_q    <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ar_q    <= ar_d;
      ac_q    <= ac_d;
      br_q    <= br_d;
      bc_q    <= bc_d;
      exp_q   <= exp_d;
      mmv_q   <= mm_valid;
      ready_q <= ready_d;
      tx_q    <= tx_d;
      ce_q    <= ce_d;
      re_q    <= re_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign ready     = ready_q;
  assign tx_data   = tx_q;
  assign col_end   = ce_q;
  assign row_end   = re_q;
  assign res_valid = rv_q;
  assign res_data  = rd_q;
  assign res_count = cnt_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mm_stream_tx.sv
// Directed bench for mm_stream_tx: streaming order/markers, result capture, bad dims, busy hold, reset abort.
module tb_mm_stream_tx;
  localparam int DW = 8;
  localparam int RW = 12;

  logic          clk = 1'b0;
  logic          rst, cfg_we, cfg_sel, start, mm_busy, mm_valid;
  logic [3:0]    cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [2:0]    a_rows, a_cols, b_rows, b_cols;
  logic          ready, col_end, row_end, res_valid, done, err;
  logic [DW-1:0] tx_data;
  logic [RW-1:0] mm_data, res_data;
  logic [4:0]    res_count;

  always #5 clk = ~clk;

  mm_stream_tx #(.MAX_DIM(4), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .start(start), .ready(ready), .tx_data(tx_data), .col_end(col_end), .row_end(row_end),
    .mm_busy(mm_busy), .mm_valid(mm_valid), .mm_data(mm_data), .res_valid(res_valid),
    .res_data(res_data), .res_count(res_count), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_data = d;
    tick;
    cfg_we = 1'b0;
  endtask

  // Expected stream entries packed as {col_end, row_end, tx_data}.
  logic [9:0] es [16];
  int         es_n;

  task automatic load_legal;
    es_n = 13;
    es[0] = {2'b00, 8'd1};  es[1] = {2'b00, 8'd2};  es[2] = {2'b10, 8'd3};
    es[3] = {2'b00, 8'd4};  es[4] = {2'b00, 8'd5};  es[5] = {2'b11, 8'd6};
    es[6] = {2'b00, 8'd0};
    es[7] = {2'b00, 8'd7};  es[8] = {2'b10, 8'd8};  es[9] = {2'b00, 8'd9};
    es[10] = {2'b10, 8'd10}; es[11] = {2'b00, 8'd11}; es[12] = {2'b11, 8'd12};
  endtask

  task automatic expect_stream;
    for (int i = 0; i < es_n; i++) begin
      chk($sformatf("stream[%0d]", i), {22'd0, col_end, row_end, tx_data}, {22'd0, es[i]});
      tick;
    end
    chk("stream_end", {22'd0, col_end, row_end, tx_data}, 32'd0);
  endtask

  task automatic start_xfer(input logic [2:0] ar, ac, br, bc);
    a_rows = ar; a_cols = ac; b_rows = br; b_cols = bc;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("ready_fall", ready, 1'b0);
    chk("cnt_clear", res_count, 5'd0);
  endtask

  task automatic give_result(input logic [RW-1:0] val, input int cnt, input logic last);
    mm_data = val; mm_valid = 1'b1;
    tick;
    chk("res_valid_hi", res_valid, 1'b1);
    chk("res_data", res_data, val);
    chk("res_count", res_count, cnt);
    mm_valid = 1'b0;
    tick;
    chk("res_valid_lo", res_valid, 1'b0);
    if (last) begin
      chk("done_hi", done, 1'b1);
      chk("ready_in_done", ready, 1'b0);
      tick;
      chk("done_lo", done, 1'b0);
      chk("ready_back", ready, 1'b1);
      chk("cnt_hold", res_count, cnt);
    end else begin
      chk("done_early", done, 1'b0);
    end
  endtask

  task automatic legal_results;
    give_result(12'd58, 1, 1'b0);
    give_result(12'd64, 2, 1'b0);
    give_result(12'd139, 3, 1'b0);
    give_result(12'd154, 4, 1'b1);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    a_rows = '0; a_cols = '0; b_rows = '0; b_cols = '0;
    start = 1'b0; mm_busy = 1'b0; mm_valid = 1'b0; mm_data = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_ready", ready, 1'b1);
    chk("rst_outs", {col_end, row_end, tx_data, res_valid, res_data, res_count, done, err}, 32'd0);

    // A = [1 2 3; 4 5 6], B = [7 8; 9 10; 11 12]
    wr(0, 4'd0, 8'd1); wr(0, 4'd1, 8'd2); wr(0, 4'd2, 8'd3);
    wr(0, 4'd4, 8'd4); wr(0, 4'd5, 8'd5); wr(0, 4'd6, 8'd6);
    wr(1, 4'd0, 8'd7); wr(1, 4'd1, 8'd8); wr(1, 4'd4, 8'd9);
    wr(1, 4'd5, 8'd10); wr(1, 4'd8, 8'd11); wr(1, 4'd9, 8'd12);

    // Legal 2x3 * 3x2
    load_legal;
    start_xfer(3'd2, 3'd3, 3'd3, 3'd2);
    tick;
    chk("lat_n1", {22'd0, col_end, row_end, tx_data}, 32'd0);
    tick;
    expect_stream;
    legal_results;

    // Mismatched inner dims 2x3 * 2x2: full stream, single response
    es_n = 11;
    es[7] = {2'b00, 8'd7}; es[8] = {2'b10, 8'd8}; es[9] = {2'b00, 8'd9}; es[10] = {2'b11, 8'd10};
    start_xfer(3'd2, 3'd3, 3'd2, 3'd2);
    tick; tick;
    expect_stream;
    wr(0, 4'd0, 8'd99);
    give_result(12'hFFF, 1, 1'b1);

    // Bad dimensions
    for (int k = 0; k < 2; k++) begin
      a_rows = (k == 0) ? 3'd0 : 3'd2; a_cols = 3'd3; b_rows = 3'd3; b_cols = (k == 0) ? 3'd2 : 3'd5;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("bad_err", err, 1'b1);
      chk("bad_ready", ready, 1'b1);
      for (int j = 0; j < 4; j++) begin
        tick;
        chk("bad_quiet", {21'd0, err, done, col_end, row_end, tx_data}, 32'd0);
      end
      chk("bad_cnt_hold", res_count, 5'd1);
    end

    // Busy hold
    load_legal;
    mm_busy = 1'b1;
    start_xfer(3'd2, 3'd3, 3'd3, 3'd2);
    for (int j = 0; j < 10; j++) begin
      tick;
      chk("busy_quiet", {22'd0, col_end, row_end, tx_data}, 32'd0);
    end
    mm_busy = 1'b0;
    tick;
    chk("busy_rel1", {22'd0, col_end, row_end, tx_data}, 32'd0);
    tick;
    expect_stream;
    legal_results;

    // Reset during SEND_B, then replay unchanged matrices
    start_xfer(3'd2, 3'd3, 3'd3, 3'd2);
    for (int j = 0; j < 9; j++) tick;
    chk("pre_rst_b0", tx_data, 8'd7);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_ready", ready, 1'b1);
    chk("abort_outs", {col_end, row_end, tx_data, res_valid, res_data, res_count, done, err}, 32'd0);
    start_xfer(3'd2, 3'd3, 3'd3, 3'd2);
    tick; tick;
    expect_stream;
    legal_results;

    // 1x1 * 1x1 with no receiver response
    es_n = 3;
    es[0] = {2'b11, 8'd1}; es[1] = {2'b00, 8'd0}; es[2] = {2'b11, 8'd7};
    start_xfer(3'd1, 3'd1, 3'd1, 3'd1);
    tick; tick;
    expect_stream;
    for (int j = 0; j < 253; j++) tick;
    chk("wd_not_yet", {30'd0, err, done}, 32'd0);
    tick;
`ifdef MM_TX_TIMEOUT_EN
    chk("timeout_pulse", {30'd0, err, done}, 32'd3);
    chk("timeout_cnt", res_count, 5'd0);
    tick;
    chk("timeout_ready", ready, 1'b1);
`else
    chk("no_timeout", {29'd0, err, done, ready}, 32'd0);
    give_result(12'd7, 1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
